// File: rtl/imem_loader_if.sv
// Stream and instruction-memory write bus for imem_loader.
//   in_valid / in_data / in_ready : byte stream with valid/ready handshake
//   we / waddr / wdata            : one-cycle word write into instruction memory
// master drives the byte stream; slave is the loader, which drives in_ready and the write bus.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader for the instruction memory.
// Takes a frame LEN_HI, LEN_LO, 4*N data bytes (big-endian words), CSUM (XOR of data bytes),
// writes each assembled word to BASE_ADDR + 4*idx and holds the CPU in reset until a load
// finishes with a matching checksum.
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      begin a load (honoured only in IDLE, DONE, ERR)
//   bus          imem_loader_if.slave: byte stream in, word write out
//   cpu_reset_o  processor hold-reset, low only in DONE
//   busy_o       load in progress
//   done_o       last load succeeded
//   err_o        last load failed (length or checksum)
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    imem_loader_if.slave bus,
    output logic         cpu_reset_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    // One extra bit so a full-depth load can count up to DEPTH_WORDS.
    localparam int unsigned CntW = IdxW + 1;

    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StCsum, StDone, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [CntW-1:0]   nwords_q, nwords_d;
    logic [CntW-1:0]   wcnt_q, wcnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [31:0]       waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              in_ready;
    logic              accept;
    logic [15:0]       len_word;

    assign in_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                      (state_q == StData)  || (state_q == StCsum);
    assign accept   = bus.in_valid && in_ready;
    assign len_word = {len_hi_q, bus.in_data};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            len_hi_q   <= '0;
            nwords_q   <= '0;
            wcnt_q     <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= BASE_ADDR;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            nwords_q   <= nwords_d;
            wcnt_q     <= wcnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        nwords_d   = nwords_q;
        wcnt_d     = wcnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    state_d    = StLenHi;
                    byte_cnt_d = '0;
                    wcnt_d     = '0;
                    xor_d      = '0;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = bus.in_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    if (len_word == 16'd0) begin
                        state_d = StCsum;
                    end else if (32'(len_word) > DEPTH_WORDS) begin
                        state_d = StErr;
                    end else begin
                        nwords_d = CntW'(len_word);
                        state_d  = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    xor_d      = xor_q ^ bus.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], bus.in_data};
                    if (byte_cnt_q == 2'd3) begin
                        // Earlier bytes of the word sit in shift_q, MSB first.
                        we_d    = 1'b1;
                        wdata_d = {shift_q, bus.in_data};
                        waddr_d = BASE_ADDR + {{(30 - IdxW){1'b0}}, wcnt_q[IdxW-1:0], 2'b00};
                        wcnt_d  = wcnt_q + CntW'(1);
                        if (wcnt_q + CntW'(1) == nwords_q) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (bus.in_data == xor_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign busy_o       = in_ready;
    assign done_o       = (state_q == StDone);
    assign err_o        = (state_q == StErr);
    assign cpu_reset_o  = (state_q != StDone);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good frame, stalled stream, bad checksum,
// oversize length, empty frame, mid-load reset, ignored start and reload.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_reset, busy, done, err;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic        wr_q[$];

    imem_loader_if lif ();

    imem_loader #(
        .BASE_ADDR  (32'h0000_3000),
        .DEPTH_WORDS(1024)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .bus        (lif),
        .cpu_reset_o(cpu_reset),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every write strobe together with its cycle and whether the loader was in a ready state.
    always @(negedge clk) begin
        if (lif.we === 1'b1) begin
            wa_q.push_back(lif.waddr);
            wd_q.push_back(lif.wdata);
            wc_q.push_back(cyc);
            wr_q.push_back(lif.in_ready);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit st);
        int n = 0;
        @(negedge clk);
        lif.in_valid = 1'b1;
        lif.in_data  = b;
        start        = st;
        while (lif.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (lif.in_ready !== 1'b1) begin
            check("send_ready_timeout", {31'd0, lif.in_ready}, 32'd1);
            lif.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (gap) begin
            @(negedge clk);
            lif.in_valid = 1'b0;
            start        = 1'b0;
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        lif.in_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        lif.in_valid = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        wr_q.delete();
    endtask

    // N=2 frame: 3C011234, 00000000, then csum; start pulsed with byte st_at (-1 = never).
    task automatic send_frame(input logic [7:0] csum, input bit gap, input int st_at);
        logic [7:0] f [0:10];
        f = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        f[10] = csum;
        for (int i = 0; i < 11; i++) send_byte(f[i], gap, (i == st_at));
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwr"}, wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            check({tag, "_a0"}, wa_q[0], 32'h0000_3000);
            check({tag, "_d0"}, wd_q[0], 32'h3C01_1234);
            check({tag, "_a1"}, wa_q[1], 32'h0000_3004);
            check({tag, "_d1"}, wd_q[1], 32'h0000_0000);
        end
    endtask

    initial begin
        lif.in_valid = 1'b0;
        lif.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, lif.in_ready}, 32'd0);
        check("rst_we", {31'd0, lif.we}, 32'd0);
        check("rst_waddr", lif.waddr, 32'h0000_3000);
        check("rst_wdata", lif.wdata, 32'd0);
        check("rst_flags", {28'd0, cpu_reset, busy, done, err}, 32'b1000);

        // Continuous good frame.
        clear_log();
        do_start();
        check("a_start_ready", {31'd0, lif.in_ready}, 32'd1);
        check("a_start_flags", {28'd0, cpu_reset, busy, done, err}, 32'b1100);
        send_frame(8'h1B, 1'b0, -1);
        end_stream();
        check("a_result", {28'd0, cpu_reset, busy, done, err}, 32'b0010);
        check("a_in_ready", {31'd0, lif.in_ready}, 32'd0);
        check_two_writes("a");
        if (wc_q.size() == 2) begin
            check("a_spacing", wc_q[1] - wc_q[0], 32'd4);
            check("a_last_we_in_csum", {31'd0, wr_q[1]}, 32'd1);
        end

        // Stalled stream from DONE, with a stray start during DATA.
        clear_log();
        do_start();
        check("b_restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        send_frame(8'h1B, 1'b1, 4);
        end_stream();
        check("b_result", {28'd0, cpu_reset, busy, done, err}, 32'b0010);
        check_two_writes("b");

        // Bad checksum: writes stay, loader errors.
        clear_log();
        do_start();
        send_frame(8'h00, 1'b0, -1);
        end_stream();
        check("c_result", {28'd0, cpu_reset, busy, done, err}, 32'b1001);
        check_two_writes("c");

        // N=1025 is rejected right after LEN_LO.
        clear_log();
        do_start();
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        end_stream();
        check("d_result", {28'd0, cpu_reset, busy, done, err}, 32'b1001);
        check("d_in_ready", {31'd0, lif.in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("d_nwr", wa_q.size(), 32'd0);

        // Empty frame.
        clear_log();
        do_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        end_stream();
        check("e_result", {28'd0, cpu_reset, busy, done, err}, 32'b0010);
        check("e_nwr", wa_q.size(), 32'd0);

        // Reset after six data bytes, then a clean reload.
        clear_log();
        do_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        @(negedge clk);
        lif.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check("f_rst_in_ready", {31'd0, lif.in_ready}, 32'd0);
        check("f_rst_we", {31'd0, lif.we}, 32'd0);
        check("f_rst_waddr", lif.waddr, 32'h0000_3000);
        check("f_rst_wdata", lif.wdata, 32'd0);
        check("f_rst_flags", {28'd0, cpu_reset, busy, done, err}, 32'b1000);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("f_nwr_aborted", wa_q.size(), 32'd1);
        clear_log();
        do_start();
        send_frame(8'h1B, 1'b0, -1);
        end_stream();
        check("f_result", {28'd0, cpu_reset, busy, done, err}, 32'b0010);
        check_two_writes("f");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the instruction memory that the fetch unit reads. Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Issues one-cycle word writes to instruction memory, starting at the text base address. Holds the processor in reset until a load completes with a correct checksum.

## Interface
- BASE_ADDR, 32'h00003000, byte address of the first word written (instruction-memory base)
- DEPTH_WORDS, 1024, instruction-memory capacity in words; word index width is 10
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  reset; synchronous, active-high
- start  input  1  begin a load; sampled only in IDLE, DONE or ERR
- in_valid  input  1  in_data holds a byte
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- we  output  1  instruction-memory write strobe, one cycle per word
- waddr  output  32  byte address of the word being written
- wdata  output  32  word being written
- cpu_reset  output  1  hold-reset to the processor
- busy  output  1  load in progress
- done  output  1  last load completed successfully
- err  output  1  last load failed

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4N data bytes (MSB of each word first), then CSUM. CSUM is the XOR of all data bytes only.
- A byte is accepted on an edge where in_valid && in_ready. When in_valid is low, the loader holds its state; there is no timeout.
- States and transitions:
  - IDLE: in_ready=0. start → LEN_HI.
  - LEN_HI: accept a byte → LEN_LO.
  - LEN_LO: accept a byte → DATA if 0 < N <= DEPTH_WORDS; → CSUM if N=0; → ERR if N > DEPTH_WORDS.
  - DATA: accepts bytes. After the 4th byte of word N-1 → CSUM.
  - CSUM: accept a byte → DONE if it equals the running XOR, else → ERR.
  - DONE / ERR: in_ready=0. start → LEN_HI. Restarting clears the byte counter, word index and running XOR.
- in_ready=1 exactly in LEN_HI, LEN_LO, DATA and CSUM. busy is high in the same states.
- done=1 only in DONE; err=1 only in ERR.
- Word writes: waddr = BASE_ADDR + 4*idx, where idx is a 10-bit word index starting at 0. Byte order: wdata[31:24] is the first byte of the word, wdata[7:0] the fourth.
- cpu_reset is 1 in every state except DONE. It is therefore released only after a good checksum, and reasserts on start.
- start outside IDLE/DONE/ERR is ignored.
- Words written before an error or a mid-load reset stay in memory; the loader does not roll them back.

## Timing
- Reset values: state IDLE, in_ready=0, we=0, waddr=BASE_ADDR, wdata=0, cpu_reset=1, busy=0, done=0, err=0.
- Reset mid-load takes effect on the next edge. It aborts the load with no further we pulses.
- All outputs are registered or decoded from the state register, with no combinational path from any input.
- Start latency: start high at edge t (in IDLE) → in_ready=1 from the cycle after t.
- Write latency: 4th byte of a word accepted at edge t → we=1 for exactly the cycle after t, with waddr/wdata valid in that cycle.
- Throughput: at most one byte per cycle, so at most one we per 4 cycles. Writes never overlap.
- The final word's we cycle coincides with the first CSUM cycle.
- Result latency: CSUM byte accepted at edge t → done=1 and cpu_reset=0 (or err=1) from the cycle after t.
- Length error: LEN_LO accepted at edge t with N > DEPTH_WORDS → err=1 and in_ready=0 the cycle after t. No we is issued.

## Test plan
- Load N=2, words 0x3C011234, 0x00000000, CSUM 0x3C^0x01^0x12^0x34=0x1B, in_valid continuous → two we pulses, 4 cycles apart: (0x3000, 0x3C011234), then (0x3004, 0x00000000). done=1, cpu_reset=0 one cycle after CSUM.
- Same frame with in_valid toggling every other cycle → identical writes and result; no byte lost or duplicated.
- Same frame with CSUM 0x00 → both writes occur, then err=1, done=0, cpu_reset stays 1.
- Length errors and empty frames:
  - LEN bytes 0x04, 0x01 (N=1025) → err=1 after LEN_LO, no we, in_ready=0.
  - N=0 with CSUM 0x00 → done=1 with no we.
- Reset asserted after 6 data bytes → next cycle all outputs at reset values. A new start plus a full frame then loads correctly from 0x3000.
- start pulsed during DATA → ignored. start in DONE → cpu_reset=1 and a second load overwrites from 0x3000.
